dsc_mul_seq: RTL

//   Operand sequencer and result capture stage that sits directly around the
//   2-input deterministic stochastic multiplier.
//   - Accepts an operand pair over a valid/ready handshake.
//   - Clears the multiplier, enables it, and watches its early-shutoff flag.
//   - Captures the stoch2bin count and returns it with cycle count and timeout flag.

---
 rtl/dsc_mul_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture around the 2-input deterministic
// stochastic multiplier: accept a pair, clear and run the multiplier until
// its done flag (past a guard window) or the cycle cap, then return the count.
module dsc_mul_seq #(
  parameter int SNG_WIDTH    = 8,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SNG_WIDTH-1:0]   in_a,
  input  logic [SNG_WIDTH-1:0]   in_b,
  output logic [SNG_WIDTH-1:0]   mul_a,
  output logic [SNG_WIDTH-1:0]   mul_b,
  output logic                   mul_clr,
  output logic                   mul_en,
  input  logic [2*SNG_WIDTH-1:0] mul_z,
  input  logic                   mul_ov,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*SNG_WIDTH-1:0] out_z,
  output logic [2*SNG_WIDTH:0]   out_cycles,
  output logic                   out_timeout,
  output logic                   busy
);
  localparam int ZW = 2*SNG_WIDTH;
  localparam int CW = ZW+1;
  // Last legal run_cnt value; terminating here yields out_cycles = 2^ZW.
  localparam logic [CW-1:0] CAP   = {1'b0, {ZW{1'b1}}};
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DONE} state_e;

  state_e          state_q, state_d;
  logic            init_q, init_d;
  logic [SNG_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [CW-1:0]   run_cnt_q, run_cnt_d;
  logic [ZW-1:0]   out_z_q, out_z_d;
  logic [CW-1:0]   out_cycles_q, out_cycles_d;
  logic            out_timeout_q, out_timeout_d;
  logic            ov_hit, cap_hit;

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d       = state_q;
    init_d        = 1'b1;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    run_cnt_d     = run_cnt_q;
    out_z_d       = out_z_q;
    out_cycles_d  = out_cycles_q;
    out_timeout_d = out_timeout_q;
    ov_hit        = 1'b0;
    cap_hit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && init_q) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + CW'(1);
        ov_hit    = mul_ov && (run_cnt_q >= GUARD);
        cap_hit   = (run_cnt_q == CAP);
        if (ov_hit || cap_hit) begin
          out_cycles_d  = run_cnt_q + CW'(1);
          // Timeout only when the cap alone ended the run.
          out_timeout_d = !ov_hit;
          state_d       = CAPTURE;
        end
      end
      CAPTURE: begin
        // mul_z here already reflects the last enabled edge.
        out_z_d = mul_z;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run without a result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      init_q        <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      run_cnt_q     <= '0;
      out_z_q       <= '0;
      out_cycles_q  <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_q        <= init_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      run_cnt_q     <= run_cnt_d;
      out_z_q       <= out_z_d;
      out_cycles_q  <= out_cycles_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  // Control outputs decoded straight from registers; in_ready waits one
  // edge after reset release.
  assign in_ready    = (state_q == IDLE) && init_q;
  assign mul_clr     = (state_q == CLEAR);
  assign mul_en      = (state_q == RUN);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_z       = out_z_q;
  assign out_cycles  = out_cycles_q;
  assign out_timeout = out_timeout_q;
endmodule
